// File: rtl/auth_msg_assembler.sv
// auth_msg_assembler: collects the authentication message, which arrives as a
// byte stream from the PD transport layer. Byte i of the message lands in bits
// [8i+7:8i] of a 1000-bit bus. The block checks the message length and raises
// a request to the authentication responder. It holds the message stable until
// the responder acknowledges it.
// Optional header check: define AUTH_ASM_HDR_CHECK_EN to also require
// ProtocolVersion == 1 and MessageType in 129..131. Without it, err_proto
// stays 0.
module auth_msg_assembler #(
  parameter int MAX_BYTES    = 125,
  parameter int MIN_BYTES    = 4,
  parameter int BYTE_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic [8*MAX_BYTES-1:0] auth_msg_out,
  output logic                   resp_req_out,
  input  logic                   resp_ack_in,
  output logic [6:0]             msg_len,
  output logic                   err_overflow,
  output logic                   err_runt,
  output logic                   err_timeout,
  output logic                   err_proto
);

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_RECV  = 5'b00010;
  localparam logic [4:0] ST_CHECK = 5'b00100;
  localparam logic [4:0] ST_REQ   = 5'b01000;
  localparam logic [4:0] ST_DROP  = 5'b10000;

  localparam int TMO_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [6:0]       MAX_LEN  = 7'(MAX_BYTES);
  localparam logic [6:0]       MIN_LEN  = 7'(MIN_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BYTE_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [4:0]       state_reg, state_next;
  logic [6:0]       len_reg, len_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [7:0]       mem_reg [MAX_BYTES];
  logic             byte_ready_reg;
  logic             resp_req_reg;
  logic             err_overflow_reg, err_overflow_next;
  logic             err_runt_reg, err_runt_next;
  logic             err_timeout_reg, err_timeout_next;
  logic             err_proto_reg, err_proto_next;
  logic             accept;
  logic             wr_en;
  logic             clr;

  assign accept = byte_valid & byte_ready_reg;

`ifdef AUTH_ASM_HDR_CHECK_EN
  logic hdr_ok;
  assign hdr_ok = (mem_reg[0] == 8'd1) && (mem_reg[1] >= 8'd129) && (mem_reg[1] <= 8'd131);
`endif

  // Next-state, slot-write and error decisions for the one-hot FSM
  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    tmo_next          = tmo_reg;
    wr_en             = 1'b0;
    clr               = 1'b0;
    err_overflow_next = 1'b0;
    err_runt_next     = 1'b0;
    err_timeout_next  = 1'b0;
    err_proto_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        tmo_next = '0;
        if (accept) begin
          wr_en      = 1'b1;
          len_next   = len_reg + 7'd1;
          // A single-byte message still goes through CHECK so runt is flagged there
          state_next = byte_last ? ST_CHECK : ST_RECV;
        end
      end
      ST_RECV: begin
        if (accept) begin
          tmo_next = '0;
          if (len_reg == MAX_LEN) begin
            // Byte MAX_BYTES+1: report it and throw it away
            err_overflow_next = 1'b1;
            if (byte_last) begin
              clr        = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DROP;
            end
          end else begin
            wr_en    = 1'b1;
            len_next = len_reg + 7'd1;
            if (byte_last) state_next = ST_CHECK;
          end
        end else if (tmo_reg == TMO_LAST) begin
          err_timeout_next = 1'b1;
          clr              = 1'b1;
          state_next       = ST_IDLE;
        end else begin
          tmo_next = tmo_reg + TMO_ONE;
        end
      end
      ST_DROP: begin
        // Drain the rest of an oversized message; the error has already been reported
        if (accept) begin
          tmo_next = '0;
          if (byte_last) begin
            clr        = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (tmo_reg == TMO_LAST) begin
          clr        = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_next = tmo_reg + TMO_ONE;
        end
      end
      ST_CHECK: begin
        if (len_reg < MIN_LEN) begin
          err_runt_next = 1'b1;
          clr           = 1'b1;
          state_next    = ST_IDLE;
        end else begin
`ifdef AUTH_ASM_HDR_CHECK_EN
          if (!hdr_ok) begin
            err_proto_next = 1'b1;
            clr            = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            state_next = ST_REQ;
          end
`else
          state_next = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (resp_ack_in) begin
          clr        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        clr        = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
    if (clr) begin
      len_next = '0;
      tmo_next = '0;
    end
  end

  // Control state and registered outputs; byte_ready and the request follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      len_reg          <= '0;
      tmo_reg          <= '0;
      byte_ready_reg   <= 1'b0;
      resp_req_reg     <= 1'b0;
      err_overflow_reg <= 1'b0;
      err_runt_reg     <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_proto_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      len_reg          <= len_next;
      tmo_reg          <= tmo_next;
      byte_ready_reg   <= (state_next == ST_IDLE) || (state_next == ST_RECV) ||
                          (state_next == ST_DROP);
      resp_req_reg     <= (state_next == ST_REQ);
      err_overflow_reg <= err_overflow_next;
      err_runt_reg     <= err_runt_next;
      err_timeout_reg  <= err_timeout_next;
      err_proto_reg    <= err_proto_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_slot
      // Each slot captures the byte written at its index and returns to 0 when the message is dropped or done
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem_reg[gi] <= 8'd0;
        end else if (clr) begin
          mem_reg[gi] <= 8'd0;
        end else if (wr_en && (len_reg == 7'(gi))) begin
          mem_reg[gi] <= byte_in;
        end
      end
      assign auth_msg_out[8*gi +: 8] = mem_reg[gi];
    end
  endgenerate

  assign byte_ready   = byte_ready_reg;
  assign resp_req_out = resp_req_reg;
  assign msg_len      = len_reg;
  assign err_overflow = err_overflow_reg;
  assign err_runt     = err_runt_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_proto    = err_proto_reg;

endmodule

// File: doc/auth_msg_assembler.md
# auth_msg_assembler

- Sits directly upstream of the authentication responder.
- Accepts the authentication message as a byte stream from the PD transport layer and assembles it, little-endian, into the 1000-bit message bus that the responder reads.
- Validates the message length, and optionally the protocol version.
- Raises a request to the responder and holds the message stable until the responder acknowledges it.

## Interface
Parameters:
- MAX_BYTES, 125: buffer capacity in bytes; 125 × 8 = 1000 bits.
- MIN_BYTES, 4: minimum legal message length, which is the header size.
- BYTE_TIMEOUT, 1000: idle cycles allowed between bytes while receiving.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- byte_in  in  8  transport data byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  marks the final byte of the message; qualified by byte_valid.
- byte_ready  out  1  assembler can accept a byte.
- auth_msg_out  out  1000  assembled message; byte i sits at bits [8i+7:8i]; connects to the responder's auth_msg_resp_in.
- resp_req_out  out  1  message-ready request; connects to the responder's resp_req_in.
- resp_ack_in  in  1  responder done; driven by the responder's resp_req_out.
- msg_len  out  7  accepted byte count of the current or held message.
- err_overflow  out  1  one-cycle pulse: message longer than MAX_BYTES.
- err_runt  out  1  one-cycle pulse: message shorter than MIN_BYTES.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout expired.
- err_proto  out  1  one-cycle pulse: header check failed. Stays 0 when the header check is not compiled in.

## Operation
- A byte is accepted on any rising edge where byte_valid & byte_ready.
- Each accepted byte is written to slot msg_len, then msg_len increments.
- Unwritten slots read 0.
- States (one-hot): IDLE, RECV, CHECK, REQ, DROP.
- IDLE: byte_ready=1.
  - Accepted byte without last → RECV.
  - Accepted byte with last → runt handling.
- RECV: byte_ready=1; the timeout counter increments on every cycle with no accepted byte and clears on each accept.
  - Accepted byte with last → CHECK.
  - Counter reaches BYTE_TIMEOUT → pulse err_timeout, clear buffer and msg_len, → IDLE.
  - Accepting byte MAX_BYTES+1 without last → pulse err_overflow, discard the byte → DROP.
  - Byte MAX_BYTES+1 arriving with last → pulse err_overflow, clear → IDLE.
- DROP: byte_ready=1; bytes are consumed and discarded.
  - Accepted byte with last → clear → IDLE.
  - Timeout also applies here: clear → IDLE, but no err_timeout pulse.
- CHECK: byte_ready=0; one-cycle state.
  - msg_len < MIN_BYTES → pulse err_runt, clear → IDLE.
  - Otherwise → REQ, unless the header check fails (see Configuration).
- REQ: byte_ready=0; resp_req_out=1; auth_msg_out and msg_len are held stable.
  - resp_ack_in=1 → clear buffer and msg_len, deassert resp_req_out → IDLE.
- Runt from IDLE (single-byte message): the byte is accepted, then the path goes through CHECK → err_runt.
- resp_ack_in is ignored in every state except REQ.
- No request timeout is applied in REQ; the responder owns that timing.

## Timing
- Reset values:
  - state=IDLE.
  - byte_ready=1 once reset is released; 0 while reset=0.
  - auth_msg_out=0, msg_len=0, resp_req_out=0.
  - All err_* = 0.
- Latency: last byte accepted at edge N → CHECK during cycle N to N+1 → resp_req_out=1 from edge N+1 until the edge that samples resp_ack_in=1.
- resp_req_out is 0 from the edge after the ack, and byte_ready is 1 on that same edge.
- Sustained throughput: one byte per cycle.
- All outputs are registered; err_* pulses last exactly one cycle.
- Reset asserted mid-message or in REQ: outputs go to reset values immediately (asynchronously). The partial message is lost and no error pulse is produced.
- byte_valid=1 while byte_ready=0: the byte is not consumed; the transport must hold it.

## Configuration
- AUTH_ASM_HDR_CHECK_EN defined:
  - CHECK additionally requires byte 0 (ProtocolVersion) == 1 and byte 1 (MessageType) in 129..131.
  - On failure: pulse err_proto, clear → IDLE; no request is raised.
  - The runt check has priority over the header check.
- AUTH_ASM_HDR_CHECK_EN undefined:
  - No header check is done; every message of legal length is forwarded, and header errors are left to the responder.
  - err_proto is tied to 0.

## Test plan
- 36-byte stream, byte 0=0x01, byte 1=0x82, last on byte 36 → resp_req_out=1 one cycle after last accept; msg_len=36; auth_msg_out[15:0]=0x8201; bits [999:288]=0. Ack after 5 cycles → IDLE with all outputs 0.
- 3-byte message → err_runt pulses once; resp_req_out stays 0; msg_len returns to 0.
- 130 bytes with last on byte 130 → err_overflow pulses on byte 126; bytes 127–130 are consumed; no request; next message assembles correctly.
- 10 bytes, then valid held low for BYTE_TIMEOUT cycles → err_timeout pulses; next byte starts a fresh message at slot 0.
- With AUTH_ASM_HDR_CHECK_EN defined: 8-byte message with byte 0=0x02 → err_proto pulses, no request. Same message with the macro undefined → request is raised.
- Reset driven low during REQ and during RECV → immediate return to reset values; byte_valid pulses asserted while reset=0 are not accepted.
